// File: rtl/uart_transceiver.sv
// 8N1 UART transmitter and receiver sharing one system clock, with an
// unread-byte flag and a sticky overrun flag on the receive side.
module uart_transceiver #(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       UART_RX,
    output logic       UART_TX,
    input  logic [7:0] UART_TXD,
    input  logic       TX_EN,
    output logic       TX_STATUS,
    output logic [7:0] UART_RXD,
    output logic       RX_EFF,
    input  logic       RX_READ,
    output logic       RX_OVR
);

    localparam int unsigned DIV = CLK_FREQ / (BAUD * 16);
    localparam int unsigned BIT = 16 * DIV;
    localparam int unsigned CW  = $clog2(BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(8 * DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_idx;
    logic [7:0]    tx_shift;

    state_t        rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_idx;
    logic [7:0]    rx_shift;
    logic          rx_s1, rx_s2, rx_prev;
    logic          rx_done;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            tx_state  <= IDLE;
            tx_cnt    <= '0;
            tx_idx    <= '0;
            tx_shift  <= '0;
            UART_TX   <= 1'b1;
            TX_STATUS <= 1'b1;
        end else begin
            case (tx_state)
                IDLE: if (TX_EN) begin
                    tx_shift  <= UART_TXD;
                    tx_cnt    <= '0;
                    tx_idx    <= '0;
                    UART_TX   <= 1'b0;
                    TX_STATUS <= 1'b0;
                    tx_state  <= START;
                end
                START: if (tx_cnt == BIT_LAST) begin
                    tx_cnt   <= '0;
                    UART_TX  <= tx_shift[0];
                    tx_shift <= {1'b0, tx_shift[7:1]};
                    tx_state <= DATA;
                end else begin
                    tx_cnt <= tx_cnt + CW'(1);
                end
                DATA: if (tx_cnt == BIT_LAST) begin
                    tx_cnt <= '0;
                    if (tx_idx == 3'd7) begin
                        UART_TX  <= 1'b1;
                        tx_state <= STOP;
                    end else begin
                        UART_TX  <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_idx   <= tx_idx + 3'd1;
                    end
                end else begin
                    tx_cnt <= tx_cnt + CW'(1);
                end
                STOP: if (tx_cnt == BIT_LAST) begin
                    tx_cnt    <= '0;
                    TX_STATUS <= 1'b1;
                    tx_state  <= IDLE;
                end else begin
                    tx_cnt <= tx_cnt + CW'(1);
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    // Stop-bit sample of 1 completes a valid byte this cycle.
    assign rx_done = (rx_state == STOP) && (rx_cnt == BIT_LAST) && rx_s2;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
        end else begin
            rx_s1   <= UART_RX;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            case (rx_state)
                IDLE: if (rx_prev && !rx_s2) begin
                    rx_cnt   <= '0;
                    rx_state <= START;
                end
                START: if (rx_cnt == HALF_LAST) begin
                    rx_cnt   <= '0;
                    rx_idx   <= '0;
                    rx_state <= rx_s2 ? IDLE : DATA;
                end else begin
                    rx_cnt <= rx_cnt + CW'(1);
                end
                DATA: if (rx_cnt == BIT_LAST) begin
                    rx_cnt   <= '0;
                    rx_shift <= {rx_s2, rx_shift[7:1]};
                    if (rx_idx == 3'd7) rx_state <= STOP;
                    else                rx_idx   <= rx_idx + 3'd1;
                end else begin
                    rx_cnt <= rx_cnt + CW'(1);
                end
                STOP: if (rx_cnt == BIT_LAST) begin
                    rx_cnt   <= '0;
                    rx_state <= IDLE;
                end else begin
                    rx_cnt <= rx_cnt + CW'(1);
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

    // A completion coinciding with RX_READ leaves the overrun flag alone.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            UART_RXD <= '0;
            RX_EFF   <= 1'b0;
            RX_OVR   <= 1'b0;
        end else if (rx_done) begin
            UART_RXD <= rx_shift;
            RX_EFF   <= 1'b1;
            if (RX_EFF && !RX_READ) RX_OVR <= 1'b1;
        end else if (RX_READ) begin
            RX_EFF <= 1'b0;
            RX_OVR <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed bench for uart_transceiver at DIV=2 (32 sysclk cycles per bit).
module tb_uart_transceiver;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_line;
    logic       tx_line;
    logic [7:0] txd;
    logic       tx_en;
    logic       tx_status;
    logic [7:0] rxd;
    logic       rx_eff;
    logic       rx_read;
    logic       rx_ovr;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    uart_transceiver #(.CLK_FREQ(3200000), .BAUD(100000)) dut (
        .sysclk   (clk),
        .reset    (reset),
        .UART_RX  (rx_line),
        .UART_TX  (tx_line),
        .UART_TXD (txd),
        .TX_EN    (tx_en),
        .TX_STATUS(tx_status),
        .UART_RXD (rxd),
        .RX_EFF   (rx_eff),
        .RX_READ  (rx_read),
        .RX_OVR   (rx_ovr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Start a frame and check the line every cycle for the full 320-cycle busy time.
    // With poke set, a second request and a data change land mid-frame.
    task automatic tx_frame(input logic [7:0] d, input logic poke);
        logic [9:0] f;
        f = {1'b1, d, 1'b0};
        txd = d;
        tx_en = 1'b1;
        @(negedge clk);
        tx_en = 1'b0;
        for (int unsigned i = 0; i < 320; i++) begin
            check("tx_line", 32'(tx_line), 32'((f >> (i / 32)) & 10'd1));
            check("tx_busy", 32'(tx_status), 32'd0);
            if (poke && i == 40) begin
                txd = ~d;
                tx_en = 1'b1;
            end else if (poke && i == 41) begin
                tx_en = 1'b0;
            end
            @(negedge clk);
        end
        check("tx_idle_status", 32'(tx_status), 32'd1);
        check("tx_idle_line", 32'(tx_line), 32'd1);
    endtask

    // Drive one frame on the RX line; with precise set, check the flag edge
    // one cycle after the stop-bit mid-sample (cycle 307 from the start edge).
    task automatic rx_send(input logic [7:0] d, input logic stop_bit, input logic precise);
        logic [9:0] f;
        f = {stop_bit, d, 1'b0};
        for (int unsigned k = 0; k < 320; k++) begin
            rx_line = f[0];
            f = f >> (k % 32 == 31 ? 1 : 0);
            @(negedge clk);
            if (precise && k + 1 == 306) check("rx_eff_before_stop", 32'(rx_eff), 32'd0);
            if (precise && k + 1 == 307) begin
                check("rx_eff_at_stop", 32'(rx_eff), 32'd1);
                check("rx_data_at_stop", 32'(rxd), 32'(d));
            end
        end
    endtask

    task automatic read_pulse();
        rx_read = 1'b1;
        @(negedge clk);
        rx_read = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        rx_line = 1'b1;
        txd = '0;
        tx_en = 1'b0;
        rx_read = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_tx", 32'(tx_line), 32'd1);
        check("rst_status", 32'(tx_status), 32'd1);
        check("rst_rxd", 32'(rxd), 32'h00);
        check("rst_eff", 32'(rx_eff), 32'd0);
        check("rst_ovr", 32'(rx_ovr), 32'd0);
        repeat (5) @(negedge clk);

        tx_frame(8'hA5, 1'b0);
        repeat (5) @(negedge clk);
        tx_frame(8'h3C, 1'b1);
        repeat (5) @(negedge clk);

        rx_send(8'h3C, 1'b1, 1'b1);
        check("rx1_data", 32'(rxd), 32'h3C);
        check("rx1_ovr", 32'(rx_ovr), 32'd0);
        read_pulse();
        check("rx1_read_eff", 32'(rx_eff), 32'd0);

        rx_send(8'h11, 1'b1, 1'b0);
        rx_send(8'h22, 1'b1, 1'b0);
        check("ovr_data", 32'(rxd), 32'h22);
        check("ovr_eff", 32'(rx_eff), 32'd1);
        check("ovr_flag", 32'(rx_ovr), 32'd1);
        read_pulse();
        check("ovr_read_eff", 32'(rx_eff), 32'd0);
        check("ovr_read_flag", 32'(rx_ovr), 32'd0);

        rx_line = 1'b0;
        repeat (10) @(negedge clk);
        rx_line = 1'b1;
        repeat (40) @(negedge clk);
        check("false_start_eff", 32'(rx_eff), 32'd0);
        check("false_start_rxd", 32'(rxd), 32'h22);
        rx_send(8'h5A, 1'b1, 1'b1);
        check("after_false_data", 32'(rxd), 32'h5A);
        read_pulse();
        check("after_false_read", 32'(rx_eff), 32'd0);

        rx_send(8'h77, 1'b0, 1'b0);
        rx_line = 1'b1;
        repeat (40) @(negedge clk);
        check("frame_err_eff", 32'(rx_eff), 32'd0);
        check("frame_err_rxd", 32'(rxd), 32'h5A);
        check("frame_err_ovr", 32'(rx_ovr), 32'd0);

        fork
            tx_frame(8'h96, 1'b0);
            rx_send(8'hC3, 1'b1, 1'b1);
        join
        check("duplex_rxd", 32'(rxd), 32'hC3);
        read_pulse();
        check("duplex_read", 32'(rx_eff), 32'd0);

        txd = 8'h0F;
        tx_en = 1'b1;
        rx_line = 1'b0;
        @(negedge clk);
        tx_en = 1'b0;
        repeat (99) @(negedge clk);
        reset = 1'b1;
        rx_line = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_tx", 32'(tx_line), 32'd1);
        check("midrst_status", 32'(tx_status), 32'd1);
        check("midrst_rxd", 32'(rxd), 32'h00);
        check("midrst_eff", 32'(rx_eff), 32'd0);
        repeat (400) @(negedge clk);
        check("midrst_rx_discard", 32'(rx_eff), 32'd0);
        check("midrst_tx_quiet", 32'(tx_line), 32'd1);
        tx_frame(8'hFF, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_transceiver.md
UART_TRANSCEIVER -- requirements
Module: uart_transceiver

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, sysclk frequency in Hz.
REQ-002 Parameter BAUD, default 9600, line rate in bit/s.
REQ-003 Derived constant DIV = CLK_FREQ/(BAUD*16), truncated, SHALL be ≥1; one bit period is BIT = 16*DIV sysclk cycles.
REQ-004 Port sysclk, input, 1, sole clock; all state on rising edge.
REQ-005 Port reset, input, 1, synchronous, active-high reset.
REQ-006 Port UART_RX, input, 1, asynchronous serial line in, idle high.
REQ-007 Port UART_TX, output, 1, serial line out, idle high, registered.
REQ-008 Port UART_TXD, input, 8, byte to transmit.
REQ-009 Port TX_EN, input, 1, one-cycle transmit request.
REQ-010 Port TX_STATUS, output, 1, 1 = transmitter idle and ready.
REQ-011 Port UART_RXD, output, 8, last received byte.
REQ-012 Port RX_EFF, output, 1, 1 = UART_RXD holds an unread byte.
REQ-013 Port RX_READ, input, 1, one-cycle acknowledge clearing RX_EFF.
REQ-014 Port RX_OVR, output, 1, sticky overrun flag.

Function
REQ-015 Frame format SHALL be 8N1: start 0, data bits LSB first, stop 1; each bit held exactly BIT cycles.
REQ-016 TX FSM states IDLE, START, DATA, STOP; TX_STATUS=1 only in IDLE.
REQ-017 TX_EN with TX_STATUS=1 SHALL latch UART_TXD, enter START; UART_TX=0 and TX_STATUS=0 from the next cycle.
REQ-018 TX_EN while TX_STATUS=0 SHALL be ignored; later UART_TXD changes SHALL not affect the frame in flight.
REQ-019 After STOP holds BIT cycles, FSM returns to IDLE, TX_STATUS=1 the following cycle; total busy time = 10*BIT cycles.
REQ-020 UART_RX SHALL pass a 2-flop synchronizer (reset value 1) before any use.
REQ-021 RX FSM states IDLE, START, DATA, STOP; IDLE→START on synchronized 1→0 transition.
REQ-022 In START, sample at 8*DIV cycles after the edge; sample 1 → false start, return to IDLE with no flag change.
REQ-023 Data bits SHALL be sampled at BIT-cycle intervals after the start mid-point, LSB first; stop bit sampled BIT cycles after bit 7.
REQ-024 Stop sample 1 → UART_RXD updated and RX_EFF=1 on the next cycle; stop sample 0 (framing error) → byte discarded, outputs unchanged.
REQ-025 After the stop sample the RX FSM returns to IDLE immediately, ready for a start edge.
REQ-026 RX_READ SHALL clear RX_EFF on the next cycle; RX_READ with RX_EFF=0 has no effect.
REQ-027 Valid byte completion while RX_EFF=1 and RX_READ=0 → UART_RXD overwritten, RX_EFF stays 1, RX_OVR set.
REQ-028 Valid byte completion in the same cycle as RX_READ → new byte loaded, RX_EFF stays 1, RX_OVR unchanged.
REQ-029 RX_READ SHALL also clear RX_OVR unless REQ-027 sets it in the same cycle (set wins).
REQ-030 TX and RX paths SHALL be fully independent; simultaneous TX and RX traffic allowed.

Reset
REQ-031 On reset: UART_TX=1, TX_STATUS=1, UART_RXD=8'h00, RX_EFF=0, RX_OVR=0, both FSMs IDLE, all counters 0, synchronizer flops 1.
REQ-032 Reset asserted mid-frame SHALL abort both frames; UART_TX=1 from the cycle after reset is sampled; partial RX byte is discarded.

Verification (CLK_FREQ=3200000, BAUD=100000 → DIV=2, BIT=32)
REQ-033 TX_EN pulse, UART_TXD=8'hA5 → UART_TX: 0 for 32 cycles, then 1,0,1,0,0,1,0,1 (32 each), 1 for 32; TX_STATUS low for exactly 320 cycles.
REQ-034 Drive RX frame 8'h3C at BIT=32 → RX_EFF=1 with UART_RXD=8'h3C one cycle after the stop mid-sample; RX_READ pulse → RX_EFF=0 next cycle.
REQ-035 Two frames 8'h11, 8'h22 with no RX_READ → UART_RXD=8'h22, RX_EFF=1, RX_OVR=1; single RX_READ clears both.
REQ-036 UART_RX low pulse of 10 cycles, then high → no RX_EFF, RX FSM back in IDLE; next valid frame 8'h5A received correctly.
REQ-037 Frame 8'h77 with stop bit 0 → RX_EFF remains 0, UART_RXD unchanged; TX_EN during busy TX → ignored, only first byte sent.
REQ-038 Reset at cycle 100 of TX frame → UART_TX=1, TX_STATUS=1 next cycle; new TX_EN 8'hFF then sends a full clean frame.
